// File: rtl/matrix_result_unloader_pkg.sv
// Shared definitions for the matrix multiplier result path.
// Holds the result store geometry defaults and the unloader state encodings so
// the controller FSM, datapath and unloader all agree on them.
package matrix_result_unloader_pkg;

    localparam int DATA_W  = 16;
    localparam int ENTRIES = 4;
    localparam int ENTRY_W = 2;

    // Unloader state encodings.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_PRESENT = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    // One streamed result entry as seen by downstream logic.
    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [ENTRY_W-1:0] index;
        logic               last;
    } result_beat_t;

endpackage

// File: rtl/matrix_result_unloader.sv
// Result RAM reader / streamer.
// When the controller holds done (Store state) and the unit is armed, each of
// the ENTRIES result words is read from the result RAM in turn and offered on a
// valid/ready port, the final one tagged with out_last. After the last
// handshake a single-cycle release pulse is issued.
//
// Ports
//   clock          single clock, all logic on its rising edge
//   reset          synchronous, active-high
//   done           controller done level
//   rd_en/rd_addr  result RAM read strobe and entry index (registered)
//   rd_data        RAM data, valid the cycle after rd_en
//   out_valid/out_ready/out_data/out_index/out_last   output stream
//   busy           high whenever not IDLE
//   release_pulse  one-cycle pulse after the last entry is accepted
//                  (named so because "release" is a reserved word)
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | waiting for done while armed
// FETCH    | rd_en high for one cycle, rd_addr = idx
// WAIT     | RAM returns data; captured into the output register
// PRESENT  | out_valid high, beat held until out_ready
// RELEASE  | release_pulse high for one cycle, idx cleared
module matrix_result_unloader
    import matrix_result_unloader_pkg::*;
#(
    parameter int P_DATA_W  = DATA_W,
    parameter int P_ENTRIES = ENTRIES,
    parameter int P_ENTRY_W = ENTRY_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 done,
    output logic                 rd_en,
    output logic [P_ENTRY_W-1:0] rd_addr,
    input  logic [P_DATA_W-1:0]  rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [P_DATA_W-1:0]  out_data,
    output logic [P_ENTRY_W-1:0] out_index,
    output logic                 out_last,
    output logic                 busy,
    output logic                 release_pulse
);

    localparam logic [P_ENTRY_W-1:0] LAST_IDX = P_ENTRY_W'(P_ENTRIES - 1);

    logic [2:0]           state;
    logic [P_ENTRY_W-1:0] idx;
    logic                 armed;
    logic                 idx_is_last;

    assign idx_is_last = (idx == LAST_IDX);
    assign out_index   = idx;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            idx           <= '0;
            armed         <= 1'b1;
            rd_en         <= 1'b0;
            rd_addr       <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            rd_en         <= 1'b0;
            release_pulse <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // armed only returns once done has been seen low, so a
                    // long done level produces exactly one unload.
                    if (done && armed) begin
                        state   <= ST_FETCH;
                        armed   <= 1'b0;
                        rd_en   <= 1'b1;
                        rd_addr <= idx;
                    end else if (!done) begin
                        armed <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    out_data  <= rd_data;
                    out_last  <= idx_is_last;
                    out_valid <= 1'b1;
                    state     <= ST_PRESENT;
                end

                ST_PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (idx_is_last) begin
                            state         <= ST_RELEASE;
                            release_pulse <= 1'b1;
                        end else begin
                            // Read strobe for the next entry issues from this
                            // edge so FETCH sees it registered.
                            idx     <= idx + 1'b1;
                            rd_en   <= 1'b1;
                            rd_addr <= idx + 1'b1;
                            state   <= ST_FETCH;
                        end
                    end
                end

                ST_RELEASE: begin
                    idx   <= '0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_result_unloader.sv
// Self-checking bench for matrix_result_unloader.
module tb_matrix_result_unloader;

    logic        clock = 1'b0;
    logic        reset;
    logic        done;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        release_pulse;

    matrix_result_unloader dut (
        .clock         (clock),
        .reset         (reset),
        .done          (done),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_index     (out_index),
        .out_last      (out_last),
        .busy          (busy),
        .release_pulse (release_pulse)
    );

    always #5 clock = ~clock;

    // Result RAM model: data appears the cycle after rd_en.
    logic [15:0] mem [4];
    always @(posedge clock) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    int cyc = 0;
    always @(posedge clock) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic [1:0]  idx;
        logic        last;
    } beat_t;

    beat_t exp_q [$];
    int    exp_addr = 0;
    int    rd_cnt   = 0;
    int    rel_cnt  = 0;

    // Downstream ready generator: holds ready low for stall_cfg valid cycles
    // on each beat; with stall_cfg == 0 ready is high before valid arrives.
    int stall_cfg = 0;
    int stall_cnt = 0;
    always @(posedge clock) begin
        #2;
        if (stall_cfg == 0) begin
            out_ready = 1'b1;
        end else if (!out_valid) begin
            out_ready = 1'b0;
            stall_cnt = stall_cfg;
        end else if (!out_ready) begin
            if (stall_cnt > 0) stall_cnt--;
            else out_ready = 1'b1;
        end
    end

    // Output monitor / scoreboard.
    logic        hold_valid = 1'b0;
    logic [15:0] hold_data;
    logic [1:0]  hold_idx;
    logic        prev_rd = 1'b0, prev_rel = 1'b0, prev_hs = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            hold_valid = 1'b0;
            prev_rd    = 1'b0;
            prev_rel   = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_hs) check("valid_drop_after_accept", out_valid, 0);
            if (rd_en) begin
                check("rd_en_single_pulse", prev_rd, 0);
                check("rd_addr", rd_addr, exp_addr);
                exp_addr++;
                rd_cnt++;
            end
            if (release_pulse) begin
                check("release_single_pulse", prev_rel, 0);
                rel_cnt++;
            end
            if (out_valid && hold_valid) begin
                check("held_data", out_data, hold_data);
                check("held_index", out_index, hold_idx);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %0h idx %0d expected none", out_data, out_index);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", out_data, e.data);
                    check("beat_index", out_index, e.idx);
                    check("beat_last", out_last, e.last);
                end
            end
            hold_valid = out_valid && !out_ready;
            hold_data  = out_data;
            hold_idx   = out_index;
            prev_hs    = out_valid && out_ready;
            prev_rd    = rd_en;
            prev_rel   = release_pulse;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_from_mem();
        for (int i = 0; i < 4; i++) begin
            beat_t b;
            b.data = mem[i];
            b.idx  = i[1:0];
            b.last = (i == 3);
            exp_q.push_back(b);
        end
        exp_addr = 0;
    endtask

    task automatic wait_release(input string name, input int budget);
        int start;
        int k;
        start = rel_cnt;
        k = 0;
        while (rel_cnt == start && k < budget) begin
            tick(1);
            k++;
        end
        tick(1);
        check({name, "_release_count"}, rel_cnt - start, 1);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    typedef struct {
        logic [15:0] ram      [4];
        int          stall;
        logic [15:0] exp_data [4];
        int          exp_reads;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int r0;
        int t0, t_rd, t_v, k;

        vecs[0] = '{'{16'h0011, 16'h0022, 16'h0033, 16'h0044}, 0,
                    '{16'h0011, 16'h0022, 16'h0033, 16'h0044}, 4};
        vecs[1] = '{'{16'h0011, 16'h0022, 16'h0033, 16'h0044}, 5,
                    '{16'h0011, 16'h0022, 16'h0033, 16'h0044}, 4};
        vecs[2] = '{'{16'h0000, 16'hFFFF, 16'h8000, 16'h0001}, 1,
                    '{16'h0000, 16'hFFFF, 16'h8000, 16'h0001}, 4};
        vecs[3] = '{'{16'hA5A5, 16'h5A5A, 16'h1234, 16'hFEDC}, 2,
                    '{16'hA5A5, 16'h5A5A, 16'h1234, 16'hFEDC}, 4};

        reset     = 1'b1;
        done      = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        tick(3);
        check("rst_out_valid", out_valid, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_release", release_pulse, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        reset = 1'b0;
        tick(2);

        // Table-driven unloads with different data and back-pressure.
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 4; i++) mem[i] = vecs[v].ram[i];
            stall_cfg = vecs[v].stall;
            for (int i = 0; i < 4; i++) begin
                beat_t b;
                b.data = vecs[v].exp_data[i];
                b.idx  = i[1:0];
                b.last = (i == 3);
                exp_q.push_back(b);
            end
            exp_addr = 0;
            r0 = rd_cnt;
            done = 1'b1;
            wait_release($sformatf("vec%0d", v), 400);
            done = 1'b0;
            tick(2);
            check("vec_read_count", rd_cnt - r0, vecs[v].exp_reads);
            check("vec_busy_after", busy, 0);
        end
        stall_cfg = 0;

        // Latency: rd_en one cycle, first out_valid three cycles after done.
        for (int i = 0; i < 4; i++) mem[i] = 16'h0100 + 16'(i);
        push_from_mem();
        t0 = cyc;
        done = 1'b1;
        t_rd = -1;
        t_v  = -1;
        k = 0;
        while (t_v < 0 && k < 20) begin
            tick(1);
            k++;
            if (rd_en && t_rd < 0) t_rd = cyc;
            if (out_valid && t_v < 0) t_v = cyc;
        end
        check("rd_en_latency", t_rd - t0, 1);
        check("out_valid_latency", t_v - t0, 3);
        wait_release("latency", 100);

        // done held high after release must not retrigger.
        r0 = rd_cnt;
        tick(20);
        check("no_retrigger_reads", rd_cnt - r0, 0);
        check("no_retrigger_busy", busy, 0);
        done = 1'b0;
        tick(1);
        for (int i = 0; i < 4; i++) mem[i] = 16'h0200 + 16'(i);
        push_from_mem();
        r0 = rd_cnt;
        done = 1'b1;
        wait_release("rearm", 100);
        check("rearm_reads", rd_cnt - r0, 4);
        done = 1'b0;
        tick(2);

        // One-cycle done pulse still completes a full unload.
        for (int i = 0; i < 4; i++) mem[i] = 16'h0300 + 16'(i);
        push_from_mem();
        r0 = rd_cnt;
        done = 1'b1;
        tick(1);
        done = 1'b0;
        wait_release("pulse", 100);
        check("pulse_reads", rd_cnt - r0, 4);
        tick(2);

        // Reset while presenting index 2, then restart from index 0.
        for (int i = 0; i < 4; i++) mem[i] = 16'h0400 + 16'(i);
        push_from_mem();
        stall_cfg = 50;
        done = 1'b1;
        tick(1);
        done = 1'b0;
        k = 0;
        while (!(out_valid && out_index == 2'd2) && k < 500) begin
            tick(1);
            k++;
        end
        check("reached_idx2", {out_valid, out_index}, {1'b1, 2'd2});
        reset = 1'b1;
        tick(1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_index", out_index, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_rd_en", rd_en, 0);
        check("mid_rst_release", release_pulse, 0);
        check("mid_rst_busy", busy, 0);
        reset = 1'b0;
        exp_q.delete();
        stall_cfg = 0;
        tick(2);
        for (int i = 0; i < 4; i++) mem[i] = 16'h0500 + 16'(i);
        push_from_mem();
        r0 = rd_cnt;
        done = 1'b1;
        wait_release("after_reset", 100);
        check("after_reset_reads", rd_cnt - r0, 4);
        done = 1'b0;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
